// File: rtl/qtr_array.sv
// Multi-channel QTR RC reflectance sequencer: LED settle, charge, then parallel discharge timing.
// Optional QTR_AMBIENT_EN adds a second LED-off pass reported on amb_values.
module qtr_array #(
  parameter int NUM_CH        = 8,
  parameter int CLK_FREQUENCY = 60_000_000,
  parameter int TICK_US       = 10,
  parameter int VALUE_WIDTH   = 8,
  parameter int SETTLE_TICKS  = 2,
  parameter int CHARGE_TICKS  = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en,
  output logic [NUM_CH*VALUE_WIDTH-1:0]   values,
  output logic [NUM_CH-1:0]               timeout,
`ifdef QTR_AMBIENT_EN
  output logic [NUM_CH*VALUE_WIDTH-1:0]   amb_values,
`endif
  output logic                            valid,
  output logic                            busy,
  output logic [NUM_CH-1:0]               qtr_out_en,
  output logic [NUM_CH-1:0]               qtr_out_sig,
  input  logic [NUM_CH-1:0]               qtr_in_sig,
  output logic                            qtr_ctrl
);

  localparam int TICK_COUNT = CLK_FREQUENCY / 1_000_000 * TICK_US;
  localparam int PRE_W      = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam int PH_MAX     = (SETTLE_TICKS > CHARGE_TICKS) ? SETTLE_TICKS : CHARGE_TICKS;
  localparam int PH_W       = $clog2(PH_MAX + 1);
  localparam logic [VALUE_WIDTH-1:0] MAX_VAL = '1;

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CHARGE, S_TIME, S_DONE} state_t;

  state_t                          state_q, state_d;
  logic [PRE_W-1:0]                pre_q, pre_d;
  logic [PH_W-1:0]                 ph_q, ph_d;
  logic [VALUE_WIDTH-1:0]          cnt_q, cnt_d;
  logic [NUM_CH-1:0]               cap_q, cap_d;
  logic [NUM_CH*VALUE_WIDTH-1:0]   cval_q, cval_d;
  logic [NUM_CH*VALUE_WIDTH-1:0]   values_q, values_d;
  logic [NUM_CH-1:0]               timeout_q, timeout_d;
  logic [NUM_CH-1:0]               sync1_q, sync2_q;

  logic                            tick;
  logic                            led_on;
  logic [NUM_CH-1:0]               newcap;
  logic                            all_cap;
  logic [NUM_CH*VALUE_WIDTH-1:0]   fin_val;
  logic [NUM_CH-1:0]               fin_to;

`ifdef QTR_AMBIENT_EN
  logic                            pass_q, pass_d;
  logic [NUM_CH*VALUE_WIDTH-1:0]   on_val_q, on_val_d;
  logic [NUM_CH-1:0]               on_to_q, on_to_d;
  logic [NUM_CH*VALUE_WIDTH-1:0]   amb_q, amb_d;
  assign led_on     = ~pass_q;
  assign amb_values = amb_q;
`else
  assign led_on = 1'b1;
`endif

  assign tick    = (pre_q == PRE_W'(TICK_COUNT - 1));
  assign values  = values_q;
  assign timeout = timeout_q;

  // Per-channel result as it would stand if the pass ended on this clock.
  always_comb begin
    newcap  = ~sync2_q & ~cap_q;
    all_cap = &(cap_q | newcap);
    fin_val = '0;
    fin_to  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cap_q[i])       fin_val[i*VALUE_WIDTH +: VALUE_WIDTH] = cval_q[i*VALUE_WIDTH +: VALUE_WIDTH];
      else if (newcap[i]) fin_val[i*VALUE_WIDTH +: VALUE_WIDTH] = cnt_q;
      else                fin_val[i*VALUE_WIDTH +: VALUE_WIDTH] = MAX_VAL;
      fin_to[i] = ~(cap_q[i] | newcap[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    cval_d      = cval_q;
    values_d    = values_q;
    timeout_d   = timeout_q;
`ifdef QTR_AMBIENT_EN
    pass_d      = pass_q;
    on_val_d    = on_val_q;
    on_to_d     = on_to_q;
    amb_d       = amb_q;
`endif
    qtr_out_en  = '0;
    qtr_out_sig = '0;
    qtr_ctrl    = 1'b0;
    valid       = 1'b0;
    busy        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        ph_d = '0;
        if (en) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        qtr_ctrl = 1'b1;
        if (tick) begin
          if (ph_q == PH_W'(SETTLE_TICKS - 1)) begin
            ph_d    = '0;
            state_d = S_CHARGE;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
      end
      S_CHARGE: begin
        qtr_out_en  = '1;
        qtr_out_sig = '1;
        qtr_ctrl    = led_on;
        if (tick) begin
          if (ph_q == PH_W'(CHARGE_TICKS - 1)) begin
            ph_d    = '0;
            cnt_d   = '0;
            cap_d   = '0;
            state_d = S_TIME;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
      end
      S_TIME: begin
        qtr_ctrl = led_on;
        if (tick && cnt_q != MAX_VAL) cnt_d = cnt_q + VALUE_WIDTH'(1);
        cap_d = cap_q | newcap;
        for (int i = 0; i < NUM_CH; i++)
          if (newcap[i]) cval_d[i*VALUE_WIDTH +: VALUE_WIDTH] = cnt_q;
        if (all_cap || cnt_q == MAX_VAL) begin
          ph_d = '0;
`ifdef QTR_AMBIENT_EN
          if (!pass_q) begin
            on_val_d = fin_val;
            on_to_d  = fin_to;
            pass_d   = 1'b1;
            state_d  = S_CHARGE;
          end else begin
            values_d  = on_val_q;
            timeout_d = on_to_q;
            amb_d     = fin_val;
            pass_d    = 1'b0;
            state_d   = S_DONE;
          end
`else
          values_d  = fin_val;
          timeout_d = fin_to;
          state_d   = S_DONE;
`endif
        end
      end
      S_DONE: begin
        valid   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Prescaler restarts on every state entry so each phase begins on a tick boundary.
    if (state_d != state_q) pre_d = '0;
    else if (tick)          pre_d = '0;
    else                    pre_d = pre_q + PRE_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      ph_q      <= '0;
      cnt_q     <= '0;
      cap_q     <= '0;
      cval_q    <= '0;
      values_q  <= '0;
      timeout_q <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
`ifdef QTR_AMBIENT_EN
      pass_q    <= 1'b0;
      on_val_q  <= '0;
      on_to_q   <= '0;
      amb_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      cval_q    <= cval_d;
      values_q  <= values_d;
      timeout_q <= timeout_d;
      sync1_q   <= qtr_in_sig;
      sync2_q   <= sync1_q;
`ifdef QTR_AMBIENT_EN
      pass_q    <= pass_d;
      on_val_q  <= on_val_d;
      on_to_q   <= on_to_d;
      amb_q     <= amb_d;
`endif
    end
  end

endmodule

// File: doc/qtr_array.md
Name: qtr_array

Overview:
- Multi-channel successor to the single-channel QTR reflectance interface; drives NUM_CH Pololu QTR RC sensor pins from one shared sequencer.
- Each measurement cycle turns on the emitter LED, waits a settle time, charges all sensor nodes, then times each node's discharge in parallel.
- Results are reported as one VALUE_WIDTH-bit tick count per channel, with a timeout flag per channel.
- Sits between the QTR pin bank and the HBA register wrapper, which reads values/timeout when valid pulses.

Parameters:
- NUM_CH, 8, number of sensor channels (1..16).
- CLK_FREQUENCY, 60_000_000, clk frequency in Hz.
- TICK_US, 10, timing resolution in microseconds.
- TICK_COUNT, CLK_FREQUENCY/1_000_000*TICK_US, clocks per tick (derived; must be >= 2).
- VALUE_WIDTH, 8, bits per channel result; MAX_VAL = 2^VALUE_WIDTH-1.
- SETTLE_TICKS, 2, ticks the LED is on before charging (>= 1).
- CHARGE_TICKS, 1, ticks the pins are driven high (>= 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  level; while 1 the block starts a new cycle from IDLE.
- values  out  NUM_CH*VALUE_WIDTH  channel i at [i*VALUE_WIDTH +: VALUE_WIDTH].
- timeout  out  NUM_CH  bit i = channel i hit MAX_VAL without discharging.
- valid  out  1  one-clock pulse when values/timeout update.
- busy  out  1  1 in any state other than IDLE.
- qtr_out_en  out  NUM_CH  per-pin output enable (1 = drive).
- qtr_out_sig  out  NUM_CH  per-pin drive value.
- qtr_in_sig  in  NUM_CH  asynchronous pin readback.
- qtr_ctrl  out  1  emitter LED enable (1 = on).

Behaviour:
- Reset (async assert, sync release): values=0, timeout=0, valid=0, busy=0, qtr_out_en=0, qtr_out_sig=0, qtr_ctrl=0, state=IDLE, all counters 0. Reset mid-cycle releases the pins immediately.
- qtr_in_sig passes through a 2-flop synchronizer per bit; all decisions use the synchronized value (2-clock latency, not compensated).
- Tick prescaler: counts 0..TICK_COUNT-1; tick = 1 for one clock when count==TICK_COUNT-1. Cleared to 0 on every state entry, so each phase starts on a tick boundary.
- States:
  - IDLE: pins released, qtr_ctrl=0, valid=0. If en=1, go to SETTLE next clock. No requirement on qtr_in_sig.
  - SETTLE: qtr_ctrl=1. After SETTLE_TICKS ticks, go to CHARGE.
  - CHARGE: qtr_out_en=all 1, qtr_out_sig=all 1, qtr_ctrl=1. After CHARGE_TICKS ticks, clear the time counter and captured mask, then go to TIME.
  - TIME: qtr_out_en=0, qtr_out_sig=0. The time counter increments on each tick and saturates at MAX_VAL. Any channel with sync input 0 and not yet captured latches the current counter value and sets its captured bit. Multiple channels may capture on the same clock. Leave when all channels are captured, or on the clock the counter equals MAX_VAL; uncaptured channels then take MAX_VAL with timeout=1.
  - DONE (1 clock): values/timeout registered from the capture registers, valid=1, qtr_ctrl=0, go to IDLE.
- A channel already low at TIME entry captures 0.
- en falling mid-cycle has no effect; the cycle completes. en held at 1 gives back-to-back cycles with 1 IDLE clock between them.
- values/timeout hold between valid pulses.

Optional Feature:
- Macro QTR_AMBIENT_EN.
- Defined: after TIME, the block runs a second CHARGE/TIME pass with qtr_ctrl=0 (no SETTLE) and adds output port amb_values (NUM_CH*VALUE_WIDTH) holding the LED-off counts. values, timeout, amb_values and valid are all updated together in DONE. The timeout flag covers the LED-on pass only.
- Undefined: single LED-on pass and no amb_values port.

Test Plan:
Bench settings: CLK_FREQUENCY=4_000_000, TICK_US=1 (TICK_COUNT=4), NUM_CH=4, VALUE_WIDTH=4, SETTLE_TICKS=2, CHARGE_TICKS=1.
- Reset: reset=0 mid-TIME -> all outputs 0 and qtr_out_en=0 within the same clock; after release, state is IDLE and busy=0.
- Basic: en pulse; ch0..3 model pins fall 3,5,7,9 ticks after TIME entry -> valid once; values = 3,5,7,9 (±1 for synchronizer latency); timeout=0.
- Timeout: ch2 never falls -> values[2]=15, timeout=4'b0100; cycle ends when the counter reaches 15.
- Simultaneous and early: ch0 and ch1 fall on the same clock at tick 4, ch3 already low at TIME entry -> values[0]=values[1]=4, values[3]=0.
- Pin control: qtr_ctrl high for 8 clocks before qtr_out_en=4'hF; qtr_out_en stays high for 4 clocks, then 0; qtr_ctrl returns to 0 in DONE.
- Continuous: en held at 1 for 3 cycles -> 3 valid pulses, each separated by the full cycle length plus 1 IDLE clock; en dropped mid-SETTLE -> the current cycle still completes with valid.
